// File: rtl/dec_ttl_pkg.sv
// Shared types and constants for the XDP dec_ttl pipeline stages.
// Beat payload struct, Ethernet/IPv4 byte offsets, ethertype helper.
package dec_ttl_pkg;

  localparam int unsigned BEAT_DATA_W = 512;
  localparam int unsigned BEAT_KEEP_W = BEAT_DATA_W / 8;
  localparam int unsigned BEAT_USER_W = 48;

  localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
  localparam int unsigned ETH_TYPE_OFF  = 12;
  localparam int unsigned IP_OFF        = 14;
  localparam int unsigned CSUM_OFF      = 24;
  localparam int unsigned IP_HDR_END    = 33;

  localparam int unsigned HDR_BYTES = IP_HDR_END - IP_OFF + 1;
  localparam int unsigned HDR_W     = HDR_BYTES * 8;
  localparam int unsigned HDR_WORDS = HDR_BYTES / 2;
  localparam int unsigned CSUM_WORD = (CSUM_OFF - IP_OFF) / 2;

  localparam logic [7:0] IPV4_VER_IHL5 = 8'h45;

  typedef struct packed {
    logic [BEAT_DATA_W-1:0] tdata;
    logic [BEAT_KEEP_W-1:0] tkeep;
    logic                   tlast;
    logic [BEAT_USER_W-1:0] tuser;
    logic                   qualify;
  } beat_t;

  // True when the Ethernet ethertype field of a first beat is IPv4.
  function automatic logic is_ipv4_eth(input logic [BEAT_DATA_W-1:0] data);
    return {data[8*ETH_TYPE_OFF +: 8], data[8*(ETH_TYPE_OFF+1) +: 8]} == ETH_TYPE_IPV4;
  endfunction

endpackage

// File: rtl/ipv4_hdr_csum.sv
// Combinational IPv4 header checksum over a 20-byte header (byte 0 in the MSBs).
// The checksum field itself is excluded from the sum.
module ipv4_hdr_csum
  import dec_ttl_pkg::*;
(
  input  logic [HDR_W-1:0] hdr,
  output logic [15:0]      csum_c
);

  logic [19:0] acc;
  logic [16:0] fold1;
  logic [15:0] fold2;

  always_comb begin
    acc = '0;
    for (int unsigned k = 0; k < HDR_WORDS; k++) begin
      if (k != CSUM_WORD) begin
        acc = acc + 20'(hdr[HDR_W-1-16*k -: 16]);
      end
    end
    // Two folds cover the worst-case carry out of the 20-bit sum.
    fold1  = 17'(acc[15:0]) + 17'(acc[19:16]);
    fold2  = fold1[15:0] + 16'(fold1[16]);
    csum_c = ~fold2;
  end

endmodule

// File: rtl/ipv4_csum_fixup.sv
// Rewrites the IPv4 header checksum on the first beat of each packet after TTL decrement.
// Registered output slice plus one-entry skid register; 1-cycle latency, full throughput.
module ipv4_csum_fixup
  import dec_ttl_pkg::*;
#(
  parameter int unsigned DATA_W = 512,
  parameter int unsigned USER_W = 48,
  parameter int unsigned CNT_W  = 32
) (
  input  logic                ap_clk,
  input  logic                ap_rst_n,
  input  logic [DATA_W-1:0]   port0_tdata,
  input  logic [DATA_W/8-1:0] port0_tkeep,
  input  logic                port0_tlast,
  input  logic [USER_W-1:0]   port0_tuser,
  input  logic                port0_tvalid,
  output logic                port0_tready,
  output logic [DATA_W-1:0]   port1_tdata,
  output logic [DATA_W/8-1:0] port1_tkeep,
  output logic                port1_tlast,
  output logic [USER_W-1:0]   port1_tuser,
  output logic                port1_tvalid,
  input  logic                port1_tready,
  output logic [CNT_W-1:0]    stat_pkts,
  output logic [CNT_W-1:0]    stat_fixed,
  output logic [CNT_W-1:0]    stat_bypass
);

  logic             in_first_q;
  logic             tready_q;
  beat_t            slice_q;
  logic             slice_valid_q;
  beat_t            skid_q;
  logic             skid_full_q;
  logic             skid_full_nxt_c;
  logic             out_first_q;
  logic [CNT_W-1:0] pkts_q;
  logic [CNT_W-1:0] fixed_q;
  logic [CNT_W-1:0] bypass_q;

  logic [HDR_W-1:0] hdr_c;
  logic [15:0]      csum_c;
  logic             qualify_c;
  beat_t            in_beat_c;
  logic             in_fire_c;
  logic             out_fire_c;
  logic             slice_free_c;

  assign in_fire_c    = port0_tvalid & tready_q;
  assign out_fire_c   = slice_valid_q & port1_tready;
  assign slice_free_c = ~slice_valid_q | port1_tready;

  // IPv4 header bytes in network order, byte IP_OFF landing in the MSBs.
  always_comb begin
    hdr_c = '0;
    for (int unsigned j = 0; j < HDR_BYTES; j++) begin
      hdr_c[HDR_W-1-8*j -: 8] = port0_tdata[8*(IP_OFF+j) +: 8];
    end
  end

  ipv4_hdr_csum u_csum (
    .hdr    (hdr_c),
    .csum_c (csum_c)
  );

  assign qualify_c = in_first_q
                   && is_ipv4_eth(port0_tdata)
                   && (port0_tdata[8*IP_OFF +: 8] == IPV4_VER_IHL5)
                   && (&port0_tkeep[IP_HDR_END:0]);

  // Input beat with the checksum patched in when the packet qualifies.
  always_comb begin
    in_beat_c         = '0;
    in_beat_c.tdata   = port0_tdata;
    in_beat_c.tkeep   = port0_tkeep;
    in_beat_c.tlast   = port0_tlast;
    in_beat_c.tuser   = port0_tuser;
    in_beat_c.qualify = qualify_c;
    if (qualify_c) begin
      in_beat_c.tdata[8*CSUM_OFF +: 8]     = csum_c[15:8];
      in_beat_c.tdata[8*(CSUM_OFF+1) +: 8] = csum_c[7:0];
    end
  end

  assign skid_full_nxt_c = slice_free_c ? 1'b0 : (skid_full_q | in_fire_c);

  // Output slice, skid register and registered ready.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      slice_q       <= '0;
      slice_valid_q <= 1'b0;
      skid_q        <= '0;
      skid_full_q   <= 1'b0;
      tready_q      <= 1'b0;
      in_first_q    <= 1'b1;
    end else begin
      if (in_fire_c) begin
        in_first_q <= port0_tlast;
      end
      if (slice_free_c) begin
        if (skid_full_q) begin
          slice_q       <= skid_q;
          slice_valid_q <= 1'b1;
        end else begin
          slice_valid_q <= in_fire_c;
          if (in_fire_c) begin
            slice_q <= in_beat_c;
          end
        end
      end else if (in_fire_c) begin
        skid_q <= in_beat_c;
      end
      skid_full_q <= skid_full_nxt_c;
      tready_q    <= ~skid_full_nxt_c;
    end
  end

  // Statistics counted on the output handshake of each first beat.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      out_first_q <= 1'b1;
      pkts_q      <= '0;
      fixed_q     <= '0;
      bypass_q    <= '0;
    end else if (out_fire_c) begin
      out_first_q <= slice_q.tlast;
      if (out_first_q) begin
        pkts_q <= pkts_q + CNT_W'(1);
        if (slice_q.qualify) begin
          fixed_q <= fixed_q + CNT_W'(1);
        end else if (is_ipv4_eth(slice_q.tdata)) begin
          bypass_q <= bypass_q + CNT_W'(1);
        end
      end
    end
  end

  assign port0_tready = tready_q;
  assign port1_tdata  = slice_q.tdata;
  assign port1_tkeep  = slice_q.tkeep;
  assign port1_tlast  = slice_q.tlast;
  assign port1_tuser  = slice_q.tuser;
  assign port1_tvalid = slice_valid_q;
  assign stat_pkts    = pkts_q;
  assign stat_fixed   = fixed_q;
  assign stat_bypass  = bypass_q;

endmodule

// File: tb/tb_ipv4_csum_fixup.sv
// Self-checking bench for ipv4_csum_fixup: directed vector table, hand sequences,
// and randomized packets under backpressure checked against a behavioural model.
module tb_ipv4_csum_fixup;

  logic         ap_clk = 1'b0;
  logic         ap_rst_n;
  logic [511:0] port0_tdata;
  logic [63:0]  port0_tkeep;
  logic         port0_tlast;
  logic [47:0]  port0_tuser;
  logic         port0_tvalid;
  logic         port0_tready;
  logic [511:0] port1_tdata;
  logic [63:0]  port1_tkeep;
  logic         port1_tlast;
  logic [47:0]  port1_tuser;
  logic         port1_tvalid;
  logic         port1_tready = 1'b0;
  logic [31:0]  stat_pkts;
  logic [31:0]  stat_fixed;
  logic [31:0]  stat_bypass;

  ipv4_csum_fixup dut (
    .ap_clk       (ap_clk),
    .ap_rst_n     (ap_rst_n),
    .port0_tdata  (port0_tdata),
    .port0_tkeep  (port0_tkeep),
    .port0_tlast  (port0_tlast),
    .port0_tuser  (port0_tuser),
    .port0_tvalid (port0_tvalid),
    .port0_tready (port0_tready),
    .port1_tdata  (port1_tdata),
    .port1_tkeep  (port1_tkeep),
    .port1_tlast  (port1_tlast),
    .port1_tuser  (port1_tuser),
    .port1_tvalid (port1_tvalid),
    .port1_tready (port1_tready),
    .stat_pkts    (stat_pkts),
    .stat_fixed   (stat_fixed),
    .stat_bypass  (stat_bypass)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    logic [511:0] data;
    logic [63:0]  keep;
    logic         last;
    logic [47:0]  user;
  } exp_t;

  typedef struct {
    logic [511:0] data;
    logic [63:0]  keep;
    logic         last;
    logic [47:0]  user;
    logic [511:0] exp_data;
    int           exp_pkts;
    int           exp_fixed;
    int           exp_bypass;
  } vec_t;

  localparam logic [159:0] HDR_BASIC = 160'h4500_0073_0000_4000_3f11_0000_c0a8_0001_c0a8_00c7;
  localparam logic [159:0] HDR_ZERO  = 160'h4500_baff_0000_0000_0000_1234_0000_0000_0000_0000;
  localparam logic [159:0] HDR_CARRY = 160'h4500_ffff_ffff_ffff_ffff_0000_ffff_ffff_ffff_bb04;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   last_acc_cyc;
  int   n_sent   = 0;
  int   n_out    = 0;
  int   bp_mode  = 0;
  exp_t exp_q[$];
  logic model_first = 1'b1;
  int   m_pkts = 0, m_fixed = 0, m_bypass = 0;
  vec_t vecs[7];

  logic [511:0] last_data;
  logic [63:0]  last_keep;
  logic         last_last;
  logic [47:0]  last_user;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h required %h", nm, act, req);
  endtask

  task automatic fail_now(input string nm);
    n_checks++;
    $display("FAIL %s: bound expired or event not expected", nm);
  endtask

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [511:0] fill_pat(input int seed);
    logic [511:0] r;
    for (int i = 0; i < 64; i++) r[8*i +: 8] = 8'(i * 13 + seed);
    return r;
  endfunction

  function automatic logic [511:0] mk_first(input logic [15:0] et, input logic [159:0] hdr,
                                            input logic [511:0] fill);
    logic [511:0] d;
    d = fill;
    d[8*12 +: 8] = et[15:8];
    d[8*13 +: 8] = et[7:0];
    for (int j = 0; j < 20; j++) d[8*(14+j) +: 8] = hdr[159-8*j -: 8];
    return d;
  endfunction

  // Reference: one's-complement sum of the header words with the checksum field
  // taken as zero, folded until no carry remains, then inverted.
  function automatic logic [511:0] ref_out(input logic [511:0] d, input logic [63:0] k,
                                           input logic first, output logic qual, output logic v4);
    logic [511:0] o;
    logic [31:0]  s;
    logic [15:0]  c;
    v4   = first && d[8*12 +: 8] == 8'h08 && d[8*13 +: 8] == 8'h00;
    qual = v4 && d[8*14 +: 8] == 8'h45 && k[33:0] == {34{1'b1}};
    o    = d;
    if (qual) begin
      s = 0;
      for (int i = 14; i < 34; i += 2)
        if (i != 24) s = s + {16'h0, d[8*i +: 8], d[8*(i+1) +: 8]};
      while (s > 32'hffff) s = (s & 32'hffff) + (s >> 16);
      c = ~s[15:0];
      o[8*24 +: 8] = c[15:8];
      o[8*25 +: 8] = c[7:0];
    end
    return o;
  endfunction

  task automatic send_beat(input logic [511:0] d, input logic [63:0] k, input logic l,
                           input logic [47:0] u);
    int   n;
    logic q, v4;
    exp_t e;
    port0_tdata = d; port0_tkeep = k; port0_tlast = l; port0_tuser = u;
    port0_tvalid = 1'b1;
    n = 0;
    while (!port0_tready && n < 2000) begin @(negedge ap_clk); n++; end
    if (!port0_tready) begin
      fail_now("send_accept");
      port0_tvalid = 1'b0;
    end else begin
      e.data = ref_out(d, k, model_first, q, v4);
      e.keep = k; e.last = l; e.user = u;
      exp_q.push_back(e);
      if (model_first) begin
        m_pkts++;
        if (q) m_fixed++;
        else if (v4) m_bypass++;
      end
      model_first  = l;
      n_sent++;
      last_acc_cyc = cyc;
      @(negedge ap_clk);
      port0_tvalid = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin @(negedge ap_clk); n++; end
    if (exp_q.size() != 0) fail_now("drain");
    repeat (2) @(negedge ap_clk);
  endtask

  task automatic chk_stats(input string nm);
    chk({nm, "_pkts"},   stat_pkts,   512'(m_pkts));
    chk({nm, "_fixed"},  stat_fixed,  512'(m_fixed));
    chk({nm, "_bypass"}, stat_bypass, 512'(m_bypass));
  endtask

  // kind: 0 qualifying, 1 IPv6, 2 bad version/IHL, 3 short tkeep, 4 other ethertype
  task automatic send_pkt(input int kind, input int nb);
    logic [159:0] hdr;
    logic [511:0] d;
    logic [63:0]  k;
    logic [47:0]  u;
    logic [15:0]  et;
    logic         l;
    for (int i = 0; i < 5; i++) hdr[32*i +: 32] = $urandom;
    hdr[159:152] = 8'h45;
    u  = {16'($urandom), 32'($urandom)};
    et = 16'h0800;
    k  = {64{1'b1}};
    case (kind)
      1: et = 16'h86dd;
      2: hdr[159:152] = 8'h46 + 8'($urandom_range(0, 9));
      3: k[$urandom_range(0, 33)] = 1'b0;
      4: et = 16'($urandom) | 16'h0100;
      default: if ($urandom_range(0, 1) == 1) k[63:34] = 30'($urandom);
    endcase
    d = mk_first(et, hdr, rand512());
    for (int b = 0; b < nb; b++) begin
      l = (b == nb - 1);
      if (b > 0) begin
        d = rand512();
        k = l ? ({64{1'b1}} >> $urandom_range(0, 63)) : {64{1'b1}};
      end
      send_beat(d, k, l, u);
    end
  endtask

  task automatic do_reset_checks(input string nm);
    chk({nm, "_p1_valid"}, port1_tvalid, 0);
    chk({nm, "_p1_data"},  port1_tdata, 0);
    chk({nm, "_p1_ctl"},   {port1_tkeep, port1_tlast, port1_tuser}, 0);
    chk({nm, "_p0_ready"}, port0_tready, 0);
    chk({nm, "_stats"},    {stat_pkts, stat_fixed, stat_bypass}, 0);
  endtask

  always @(posedge ap_clk) cyc++;

  // Downstream ready pattern, updated just after each rising edge.
  initial begin
    bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    int idx = 0;
    forever begin
      @(posedge ap_clk);
      #2;
      case (bp_mode)
        0: port1_tready = 1'b1;
        1: begin port1_tready = pat[idx % 6]; idx++; end
        2: port1_tready = ($urandom_range(0, 9) < 7);
        default: port1_tready = 1'b0;
      endcase
    end
  end

  // Output monitor: scoreboard, hold-while-stalled, and ready-drop rule.
  logic         prev_stall = 1'b0;
  logic [511:0] prev_data;
  logic [63:0]  prev_keep;
  logic         prev_last;
  logic [47:0]  prev_user;
  int           since_rst = 0;
  exp_t         mon_e;
  always @(negedge ap_clk) begin
    if (!ap_rst_n) begin
      prev_stall = 1'b0;
      since_rst  = 0;
    end else begin
      if (prev_stall) begin
        chk("hold_data", port1_tdata, prev_data);
        chk("hold_ctl", {port1_tvalid, port1_tkeep, port1_tlast, port1_tuser},
            {1'b1, prev_keep, prev_last, prev_user});
      end
      if (since_rst > 0 && !port0_tready) chk("ready_low_needs_stall", prev_stall, 1);
      if (port1_tvalid && port1_tready) begin
        if (exp_q.size() == 0) fail_now("unexpected_out_beat");
        else begin
          mon_e = exp_q.pop_front();
          chk("out_data", port1_tdata, mon_e.data);
          chk("out_ctl", {port1_tkeep, port1_tlast, port1_tuser},
              {mon_e.keep, mon_e.last, mon_e.user});
        end
        last_data = port1_tdata; last_keep = port1_tkeep;
        last_last = port1_tlast; last_user = port1_tuser;
        n_out++;
      end
      prev_stall = port1_tvalid && !port1_tready;
      prev_data  = port1_tdata; prev_keep = port1_tkeep;
      prev_last  = port1_tlast; prev_user = port1_tuser;
      since_rst++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [511:0] d, e;
    logic         q, v4;
    int           c0, s0, o0;

    // Directed vector table.
    vecs[0].data = mk_first(16'h0800, HDR_BASIC, fill_pat(1));
    vecs[0].keep = {64{1'b1}}; vecs[0].last = 1'b1; vecs[0].user = 48'h62;
    vecs[0].exp_data = vecs[0].data;
    vecs[0].exp_data[8*24 +: 8] = 8'hb9; vecs[0].exp_data[8*25 +: 8] = 8'h61;
    vecs[0].exp_pkts = 1; vecs[0].exp_fixed = 1; vecs[0].exp_bypass = 0;

    vecs[1].data = mk_first(16'h86dd, HDR_BASIC, fill_pat(2));
    vecs[1].keep = {64{1'b1}}; vecs[1].last = 1'b0; vecs[1].user = 48'h46;
    vecs[1].exp_data = vecs[1].data;
    vecs[1].exp_pkts = 2; vecs[1].exp_fixed = 1; vecs[1].exp_bypass = 0;

    vecs[2].data = mk_first(16'h0800, HDR_BASIC, fill_pat(3));
    vecs[2].keep = 64'h7f; vecs[2].last = 1'b1; vecs[2].user = 48'h46;
    vecs[2].exp_data = vecs[2].data;
    vecs[2].exp_pkts = 2; vecs[2].exp_fixed = 1; vecs[2].exp_bypass = 0;

    d = mk_first(16'h0800, HDR_BASIC, fill_pat(4));
    d[8*14 +: 8] = 8'h46;
    vecs[3].data = d;
    vecs[3].keep = {64{1'b1}}; vecs[3].last = 1'b1; vecs[3].user = 48'h1234;
    vecs[3].exp_data = d;
    vecs[3].exp_pkts = 3; vecs[3].exp_fixed = 1; vecs[3].exp_bypass = 1;

    vecs[4].data = mk_first(16'h0800, HDR_BASIC, fill_pat(5));
    vecs[4].keep = 64'h0000_0000_ffff_ffff; vecs[4].last = 1'b1; vecs[4].user = 48'h20;
    vecs[4].exp_data = vecs[4].data;
    vecs[4].exp_pkts = 4; vecs[4].exp_fixed = 1; vecs[4].exp_bypass = 2;

    vecs[5].data = mk_first(16'h0800, HDR_ZERO, fill_pat(6));
    vecs[5].keep = {64{1'b1}}; vecs[5].last = 1'b1; vecs[5].user = 48'h3c;
    vecs[5].exp_data = vecs[5].data;
    vecs[5].exp_data[8*24 +: 8] = 8'h00; vecs[5].exp_data[8*25 +: 8] = 8'h00;
    vecs[5].exp_pkts = 5; vecs[5].exp_fixed = 2; vecs[5].exp_bypass = 2;

    vecs[6].data = mk_first(16'h0800, HDR_CARRY, fill_pat(7));
    vecs[6].keep = {64{1'b1}}; vecs[6].last = 1'b1; vecs[6].user = 48'h40;
    vecs[6].exp_data = vecs[6].data;
    vecs[6].exp_data[8*24 +: 8] = 8'hff; vecs[6].exp_data[8*25 +: 8] = 8'hfa;
    vecs[6].exp_pkts = 6; vecs[6].exp_fixed = 3; vecs[6].exp_bypass = 2;

    ap_rst_n = 1'b0;
    port0_tdata = '0; port0_tkeep = '0; port0_tlast = 1'b0; port0_tuser = '0;
    port0_tvalid = 1'b0;
    repeat (3) @(negedge ap_clk);
    do_reset_checks("reset");
    ap_rst_n = 1'b1;
    chk("ready_at_release", port0_tready, 0);
    @(negedge ap_clk);
    chk("ready_after_release", port0_tready, 1);

    // Table-driven directed vectors.
    for (int i = 0; i < 7; i++) begin
      send_beat(vecs[i].data, vecs[i].keep, vecs[i].last, vecs[i].user);
      drain();
      chk($sformatf("vec%0d_data", i), last_data, vecs[i].exp_data);
      chk($sformatf("vec%0d_ctl", i), {last_keep, last_last, last_user},
          {vecs[i].keep, vecs[i].last, vecs[i].user});
      chk($sformatf("vec%0d_stats", i), {stat_pkts, stat_fixed, stat_bypass},
          {32'(vecs[i].exp_pkts), 32'(vecs[i].exp_fixed), 32'(vecs[i].exp_bypass)});
    end

    // Back-to-back single-beat packets: 1-cycle latency, one beat per cycle.
    c0 = 0;
    for (int i = 0; i < 3; i++) begin
      d = mk_first(16'h0800, rand512()[159:0], rand512());
      d[8*14 +: 8] = 8'h45;
      e = ref_out(d, {64{1'b1}}, 1'b1, q, v4);
      send_beat(d, {64{1'b1}}, 1'b1, 48'(i));
      chk($sformatf("b2b%0d_valid", i), port1_tvalid, 1);
      chk($sformatf("b2b%0d_data", i), port1_tdata, e);
      if (i > 0) chk($sformatf("b2b%0d_gap", i), 512'(last_acc_cyc - c0), 1);
      c0 = last_acc_cyc;
    end
    drain();
    chk_stats("b2b");

    // Four back-to-back 2-beat packets under the fixed ready pattern.
    bp_mode = 1;
    s0 = n_sent; o0 = n_out;
    for (int i = 0; i < 4; i++) send_pkt(i % 2, 2);
    drain();
    chk("bp_beats", 512'(n_out - o0), 512'(n_sent - s0));
    chk("bp_beat_count", 512'(n_sent - s0), 8);
    chk_stats("bp");

    // Randomized packet mix under random backpressure.
    bp_mode = 2;
    for (int i = 0; i < 40; i++) begin
      send_pkt($urandom_range(0, 4), $urandom_range(1, 3));
      if ($urandom_range(0, 3) == 0) @(negedge ap_clk);
    end
    drain();
    chk_stats("rand");

    // Reset asserted with the first beat of a packet still in flight.
    bp_mode = 3;
    repeat (2) @(negedge ap_clk);
    send_beat(mk_first(16'h0800, HDR_BASIC, fill_pat(9)), {64{1'b1}}, 1'b0, 48'h77);
    ap_rst_n = 1'b0;
    exp_q.delete();
    model_first = 1'b1;
    m_pkts = 0; m_fixed = 0; m_bypass = 0;
    @(negedge ap_clk);
    do_reset_checks("midrst");
    bp_mode = 0;
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    send_beat(vecs[0].data, vecs[0].keep, vecs[0].last, vecs[0].user);
    drain();
    chk("midrst_data", last_data, vecs[0].exp_data);
    chk("midrst_stats", {stat_pkts, stat_fixed, stat_bypass}, {32'd1, 32'd1, 32'd0});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ipv4_csum_fixup.md
Name: ipv4_csum_fixup

Overview:
- Stage directly downstream of the TTL-decrement stage in the XDP dec_ttl pipeline.
- Recomputes the IPv4 header checksum on the first beat of each packet so that the decremented TTL yields a valid header.
- Passes IPv6, non-IP and unsupported IPv4 packets through unchanged.
- AXI-Stream in, AXI-Stream out, full throughput, fixed 1-cycle latency, with a skid buffer to absorb backpressure.

Parameters:
- DATA_W, 512, tdata width in bits; fixed at 512, and byte i sits at tdata[8i+7:8i].
- USER_W, 48, tuser width; carried through untouched (low bits hold the packet length).
- CNT_W, 32, width of each statistics counter.

Ports:
- ap_clk  in  1  single clock for all logic.
- ap_rst_n  in  1  reset; asynchronous assert, active-low.
- port0_tdata  in  DATA_W  input beat data.
- port0_tkeep  in  DATA_W/8  input byte enables.
- port0_tlast  in  1  last beat of packet.
- port0_tuser  in  USER_W  sideband, valid on every beat.
- port0_tvalid  in  1  input beat valid.
- port0_tready  out  1  ready to accept an input beat.
- port1_tdata  out  DATA_W  output beat data.
- port1_tkeep  out  DATA_W/8  output byte enables.
- port1_tlast  out  1  last beat of packet.
- port1_tuser  out  USER_W  sideband, passed through.
- port1_tvalid  out  1  output beat valid.
- port1_tready  in  1  downstream ready.
- stat_pkts  out  CNT_W  count of packets forwarded.
- stat_fixed  out  CNT_W  count of packets with checksum rewritten.
- stat_bypass  out  CNT_W  count of IPv4 packets not rewritten (unsupported).

Behaviour:
- Reset: all port1_* outputs 0 and port0_tready 0 while ap_rst_n=0; all stat_* 0; skid buffer empty; in_first=1.
  - port0_tready rises one cycle after reset release.
- Reset asserted mid-packet: any in-flight beats are discarded, no partial output is completed, and the block restarts expecting a first beat.
- Handshake:
  - A beat transfers when tvalid&tready on either side.
  - port1_* are held stable while port1_tvalid=1 and port1_tready=0.
  - tvalid never depends combinationally on tready.
- Output stage: a registered output slice plus a one-entry skid register.
  - port0_tready=!skid_full, driven from a register.
  - Throughput is 1 beat/cycle when port1_tready=1.
  - Latency from input handshake to port1_tvalid is 1 cycle when the path is empty.
  - When the output is stalled and the slice is full, the next accepted beat goes into skid and port0_tready drops the following cycle.
- Packet tracking: in_first is set after reset and after any accepted beat with tlast=1, and cleared after an accepted beat with tlast=0.
- A first beat qualifies for fixup iff all of the following hold:
  - byte12=0x08 and byte13=0x00;
  - byte14[7:4]=4 and byte14[3:0]=5;
  - tkeep[33:0] all ones.
- Fixup:
  - Form the ten 16-bit big-endian words from bytes 14..33, with bytes 24..25 treated as 0.
  - Sum into a 20-bit accumulator, fold the carry twice, and invert.
  - Write the result with the high byte to byte24 and the low byte to byte25.
  - All other bytes, tkeep, tlast and tuser are unchanged.
  - Computed combinationally on the input side and registered into the slice, so no extra latency.
- A computed value of 0x0000 is written as 0x0000; no 0xFFFF substitution.
- Non-qualifying first beats and all non-first beats pass bit-exact.
- Statistics:
  - Counters update on the output handshake of a first beat.
  - stat_pkts increments for every packet.
  - stat_fixed increments for qualifying packets.
  - stat_bypass increments for IPv4 ethertype packets that fail the IHL or tkeep check.
  - All counters wrap modulo 2^CNT_W without saturation.
  - A qualify flag travels with each beat in the slice and skid.
- Single-beat packets (tlast on first beat) are handled identically; the next beat is again treated as a first beat.

Decomposition:
- Package dec_ttl_pkg holds:
  - ETH_TYPE_IPV4=16'h0800;
  - byte offsets IP_OFF=14, CSUM_OFF=24, IP_HDR_END=33;
  - a beat struct {tdata, tkeep, tlast, tuser, qualify}.
- Sub-module ipv4_hdr_csum: purely combinational, takes the 160-bit header and returns a 16-bit checksum. It is reusable by the upstream TTL stage.
- Skid/slice logic stays inline.

Test Plan:
- Basic fixup:
  - Stimulus: first beat with ethertype 0800 and header 4500 0073 0000 4000 3f11 0000 c0a8 0001 c0a8 00c7 (TTL 0x3f, stale checksum), tlast=1, tuser=0x62.
  - Required response: output bytes24/25 = 0xb9/0x61, every other bit identical, tuser=0x62, stat_fixed=1, stat_pkts=1.
- IPv6 pass-through:
  - Stimulus: 2-beat packet with ethertype 86dd, tuser=0x46, second-beat tkeep=0x7F.
  - Required response: both beats bit-exact, stat_fixed=0, stat_pkts=1.
- Unsupported IPv4:
  - Stimulus: IPv4 with byte14=0x46 (IHL=6), and separately IPv4 with first-beat tkeep=0x0000_0000_FFFF_FFFF.
  - Required response: both bit-exact, stat_bypass=2.
- Backpressure:
  - Stimulus: stream 4 back-to-back 2-beat packets, with port1_tready toggled 1,0,0,1,0,1...
  - Required response: no beat lost or duplicated, output stable while stalled, port0_tready drops only when skid is full, final stat_pkts=4.
- Reset mid-packet:
  - Stimulus: assert ap_rst_n=0 after beat 1 of a 2-beat packet, release, then send the basic fixup packet.
  - Required response: all outputs 0 during reset, counters 0, next packet fixed correctly with bytes24/25 = 0xb9/0x61.
- Back-to-back single-beat packets:
  - Stimulus: 3 single-beat IPv4 packets with port1_tready=1.
  - Required response: one output beat per cycle after 1-cycle latency, each checksum correct.
